// File: rtl/cache_pkg.sv
// Shared geometry and types for the 4-way set-associative byte cache.
package cache_pkg;
    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 32;
    localparam int NUM_SETS   = 64;
    localparam int WAYS       = 4;
    localparam int OFFSET_W   = 5;
    localparam int INDEX_W    = 6;
    localparam int TAG_W      = 21;

    typedef logic [LINE_BYTES*8-1:0] line_t;
    typedef logic [TAG_W-1:0]        tag_t;
    typedef logic [1:0]              age_t;
endpackage

// File: rtl/cache_lru_4way.sv
// Per-set LRU bookkeeping: picks the victim way and produces the updated 2-bit ages.
module cache_lru_4way
    import cache_pkg::*;
(
    input  logic [WAYS-1:0]   valid,
    input  logic [2*WAYS-1:0] ages,
    input  logic              hit,
    input  logic [1:0]        hit_way,
    output logic [1:0]        touched,
    output logic [2*WAYS-1:0] ages_next
);
    logic [1:0] victim;
    logic       found_invalid;
    age_t       old_age;
    age_t       cur;

    always_comb begin
        victim        = 2'd0;
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found_invalid) begin
                victim        = 2'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages[2*w +: 2] == 2'd3) victim = 2'(w);
            end
        end

        touched = hit ? hit_way : victim;
        // Filling an empty way ages every other way as if it were the oldest.
        old_age = (hit || valid[touched]) ? ages[{touched, 1'b0} +: 2] : 2'd3;

        ages_next = '0;
        for (int w = 0; w < WAYS; w++) begin
            cur = ages[2*w +: 2];
            if (2'(w) == touched)   ages_next[2*w +: 2] = 2'd0;
            else if (cur < old_age) ages_next[2*w +: 2] = cur + 2'd1;
            else                    ages_next[2*w +: 2] = cur;
        end
    end
endmodule

// File: rtl/set_assoc_cache_4way.sv
// 4-way set-associative byte cache, write-allocate, refill from dataBlock, no write-back.
module set_assoc_cache_4way
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pa,
    input  logic              writeORread,
    input  logic [7:0]        inbyte,
    input  line_t             dataBlock,
    output logic [7:0]        cacheOutput
);
    logic [WAYS-1:0]   valid_q  [NUM_SETS];
    logic [2*WAYS-1:0] age_q    [NUM_SETS];
    tag_t              tag_mem  [NUM_SETS][WAYS];
    line_t             data_mem [NUM_SETS][WAYS];

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  idx;
    tag_t                tag;
    logic                hit;
    logic [1:0]          hit_way;
    logic [1:0]          touched;
    logic [2*WAYS-1:0]   ages_next;
    line_t               line_new;
    logic [7:0]          result;

    assign offset = pa[OFFSET_W-1:0];
    assign idx    = pa[OFFSET_W +: INDEX_W];
    assign tag    = pa[ADDR_W-1 -: TAG_W];

    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_mem[idx][w] == tag && !hit) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    cache_lru_4way u_lru (
        .valid     (valid_q[idx]),
        .ages      (age_q[idx]),
        .hit       (hit),
        .hit_way   (hit_way),
        .touched   (touched),
        .ages_next (ages_next)
    );

    // A hit rewrites its own line; a miss installs the refill line, merged with a write byte.
    always_comb begin
        line_new = hit ? data_mem[idx][hit_way] : dataBlock;
        if (writeORread) line_new[{offset, 3'b000} +: 8] = inbyte;
        result = line_new[{offset, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                age_q[s]   <= 8'b11_10_01_00;
            end
            cacheOutput <= 8'h00;
        end else begin
            valid_q[idx][touched] <= 1'b1;
            age_q[idx]            <= ages_next;
            cacheOutput           <= result;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_mem[idx][touched]  <= tag;
            data_mem[idx][touched] <= line_new;
        end
    end
endmodule

// File: tb/tb_set_assoc_cache_4way.sv
// Directed self-checking bench for set_assoc_cache_4way with hand-computed expectations.
module tb_set_assoc_cache_4way;
    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pa;
    logic         writeORread;
    logic [7:0]   inbyte;
    logic [255:0] dataBlock;
    logic [7:0]   cacheOutput;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    set_assoc_cache_4way dut (
        .clk         (clk),
        .reset       (reset),
        .pa          (pa),
        .writeORread (writeORread),
        .inbyte      (inbyte),
        .dataBlock   (dataBlock),
        .cacheOutput (cacheOutput)
    );

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (cacheOutput === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, cacheOutput, exp);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic w, input logic [7:0] b,
                          input logic [255:0] db);
        pa          = a;
        writeORread = w;
        inbyte      = b;
        dataBlock   = db;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        pa          = '0;
        writeORread = 1'b0;
        inbyte      = '0;
        dataBlock   = '0;

        do_reset();
        check("reset_out", 8'h00);

        // Held read: first cycle allocates, following cycles hit.
        access(32'h9876ABC0, 1'b0, 8'h00, 256'h123456); check("t1_miss", 8'h56);
        access(32'h9876ABC0, 1'b0, 8'h00, 256'h123456); check("t1_hit_a", 8'h56);
        access(32'h9876ABC0, 1'b0, 8'h00, 256'h123456); check("t1_hit_b", 8'h56);

        // Same set, new tag; both lines stay resident.
        access(32'hABCDABC0, 1'b0, 8'h00, 256'h123456); check("t2_miss", 8'h56);
        access(32'h9876ABC0, 1'b0, 8'h00, 256'h0);      check("t2_old_hit", 8'h56);
        access(32'hABCDABC0, 1'b0, 8'h00, 256'h0);      check("t2_new_hit", 8'h56);

        // Write hit, then read-after-write and a neighbouring byte.
        access(32'hABCDABC0, 1'b1, 8'hAA, 256'h0); check("t3_wr_hit", 8'hAA);
        access(32'hABCDABC0, 1'b1, 8'hAA, 256'h0); check("t3_wr_again", 8'hAA);
        access(32'hABCDABC0, 1'b0, 8'h00, 256'h0); check("t3_rd", 8'hAA);
        access(32'hABCDABC1, 1'b0, 8'h00, 256'h0); check("t3_rd_off1", 8'h34);

        // Write miss merges inbyte into the refill line (set 51, offset 24).
        access(32'h12345678, 1'b1, 8'hBB, 256'h666666); check("t4_wr_miss", 8'hBB);
        access(32'h12345678, 1'b0, 8'h00, 256'h0);      check("t4_rd_merged", 8'hBB);
        access(32'h12345660, 1'b0, 8'h00, 256'h0);      check("t4_rd_off0", 8'h66);
        access(32'h12345661, 1'b0, 8'h00, 256'h0);      check("t4_rd_off1", 8'h66);

        // Reset wins over a concurrent write and invalidates everything.
        pa = 32'h12345678; writeORread = 1'b1; inbyte = 8'hCC; dataBlock = '0;
        do_reset();
        check("t6_reset_out", 8'h00);
        access(32'h12345678, 1'b0, 8'h00, 256'h5A << 192); check("t6_miss_a", 8'h5A);
        access(32'h9876ABC0, 1'b0, 8'h00, 256'h99);        check("t6_miss_b", 8'h99);

        // LRU: fill set 30 with four tags, touch tag1, then tag5 must evict tag2.
        do_reset();
        check("t5_reset_out", 8'h00);
        access(32'h00000BC0, 1'b0, 8'h00, 256'h11); check("t5_fill1", 8'h11);
        access(32'h000013C0, 1'b0, 8'h00, 256'h12); check("t5_fill2", 8'h12);
        access(32'h00001BC0, 1'b0, 8'h00, 256'h13); check("t5_fill3", 8'h13);
        access(32'h000023C0, 1'b0, 8'h00, 256'h14); check("t5_fill4", 8'h14);
        access(32'h00000BC0, 1'b0, 8'h00, 256'hEE); check("t5_touch1", 8'h11);
        access(32'h00002BC0, 1'b0, 8'h00, 256'h15); check("t5_fill5", 8'h15);
        access(32'h000013C0, 1'b0, 8'h00, 256'h77); check("t5_tag2_evicted", 8'h77);
        access(32'h00000BC0, 1'b0, 8'h00, 256'hEE); check("t5_tag1_hit", 8'h11);
        access(32'h00002BC0, 1'b0, 8'h00, 256'hEE); check("t5_tag5_hit", 8'h15);
        access(32'h000023C0, 1'b0, 8'h00, 256'hEE); check("t5_tag4_hit", 8'h14);
        access(32'h00001BC0, 1'b0, 8'h00, 256'h33); check("t5_tag3_evicted", 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
